cs_frame_sched: RTL

Frame scheduler and sequencer for the CS 9-tap approximate-mean datapath. Two requesters share one CS instance. The block arbitrates whole frames between the requesters round-robin and clears the CS window before each frame. It streams samples into the datapath one per cycle, suppresses the 8 warm-up outputs, and registers valid Y results tagged with the requester id and an end-of-frame marker.

---
 rtl/cs_pkg.sv | 7 +
 rtl/cs_rr_arb.sv | 20 ++
 rtl/cs_frame_sched.sv | 118 +++++++++++
 3 files changed

// File: rtl/cs_pkg.sv
// cs_pkg: shared constants and scheduler state encoding for the CS frame scheduler.
package cs_pkg;
    localparam int CS_WIN = 9;
    localparam int CS_XW  = 8;
    localparam int CS_YW  = 10;
    typedef enum logic [1:0] {IDLE, CLR, STREAM} cs_sched_state_t;
endpackage

// File: rtl/cs_rr_arb.sv
// cs_rr_arb: 2-way round-robin arbiter; ptr holds the most recently granted requester.
module cs_rr_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt,
    output logic       ptr
);
    logic ptr_d, ptr_q;
    always_comb begin
        gnt   = (req == 2'b11) ? (ptr_q ? 2'b01 : 2'b10) : req;
        ptr_d = update ? gnt[1] : ptr_q;
    end
    always_ff @(posedge clk) begin
        if (reset) ptr_q <= 1'b1;
        else       ptr_q <= ptr_d;
    end
    assign ptr = ptr_q;
endmodule

// File: rtl/cs_frame_sched.sv
// cs_frame_sched: arbitrates whole frames between two requesters onto one CS datapath,
// clears the CS window per frame, and registers tagged results past the warm-up.
module cs_frame_sched
    import cs_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int WIN  = CS_WIN
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NREQ-1:0]                req_valid,
    input  logic [NREQ-1:0][CS_XW-1:0]     req_data,
    input  logic [NREQ-1:0]                req_last,
    output logic [NREQ-1:0]                req_ready,
    output logic [CS_XW-1:0]               cs_X,
    output logic                           cs_reset,
    input  logic [CS_YW-1:0]               cs_Y,
    output logic                           out_valid,
    output logic [CS_YW-1:0]               out_data,
    output logic                           out_id,
    output logic                           out_last,
    output logic                           err_short,
    output logic                           err_underrun
);
    cs_sched_state_t state_d, state_q;
    logic [3:0] cnt_d, cnt_q, cnt_inc;
    logic [1:0] gnt;
    logic g, update;
    logic pend_d, pend_q, last_pend_d, last_pend_q, short_pend_d, short_pend_q;
    logic out_valid_d, out_valid_q, out_id_d, out_id_q, out_last_d, out_last_q;
    logic err_short_d, err_short_q, err_underrun_d, err_underrun_q;
    logic [CS_YW-1:0] out_data_d, out_data_q;

    // The arbiter pointer doubles as the latched grant for the frame in flight.
    cs_rr_arb u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req_valid),
        .update (update),
        .gnt    (gnt),
        .ptr    (g)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pend_d         = 1'b0;
        last_pend_d    = 1'b0;
        short_pend_d   = 1'b0;
        err_underrun_d = 1'b0;
        cnt_inc        = (cnt_q == 4'(WIN)) ? cnt_q : cnt_q + 4'd1;
        update         = (state_q == IDLE) && (|gnt);
        case (state_q)
            IDLE:    state_d = update ? CLR : IDLE;
            CLR: begin
                state_d = STREAM;
                cnt_d   = '0;
            end
            STREAM: begin
                if (!req_valid[g]) begin
                    state_d        = IDLE;
                    err_underrun_d = 1'b1;
                end else begin
                    cnt_d        = cnt_inc;
                    pend_d       = cnt_inc >= 4'(WIN);
                    last_pend_d  = req_last[g];
                    short_pend_d = req_last[g] && (cnt_inc < 4'(WIN));
                    state_d      = req_last[g] ? IDLE : STREAM;
                end
            end
            default: state_d = IDLE;
        endcase
        // cs_Y is sampled one edge after the accept so it reflects that sample.
        out_valid_d = pend_q;
        out_data_d  = pend_q ? cs_Y : out_data_q;
        out_id_d    = pend_q ? g : out_id_q;
        out_last_d  = pend_q && last_pend_q;
        err_short_d = short_pend_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            pend_q         <= 1'b0;
            last_pend_q    <= 1'b0;
            short_pend_q   <= 1'b0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_id_q       <= 1'b0;
            out_last_q     <= 1'b0;
            err_short_q    <= 1'b0;
            err_underrun_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pend_q         <= pend_d;
            last_pend_q    <= last_pend_d;
            short_pend_q   <= short_pend_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_id_q       <= out_id_d;
            out_last_q     <= out_last_d;
            err_short_q    <= err_short_d;
            err_underrun_q <= err_underrun_d;
        end
    end

    assign req_ready    = (state_q == STREAM) ? (g ? 2'b10 : 2'b01) : 2'b00;
    assign cs_X         = (state_q == STREAM) ? req_data[g] : '0;
    assign cs_reset     = reset || (state_q == CLR);
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_id       = out_id_q;
    assign out_last     = out_last_q;
    assign err_short    = err_short_q;
    assign err_underrun = err_underrun_q;
endmodule
